seg_readback: RTL and testbench

SEG_READBACK -- requirements
Module: seg_readback

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_decode.sv | 35 +++
 rtl/seg_readback.sv | 133 +++++++++++++
 tb/tb_seg_readback.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment readback block: segment patterns,
// capture FSM states and parameter defaults.
package seg_pkg;

  localparam int DEF_NUM_DIGITS    = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    LATCH    = 2'd2,
    HOLD     = 2'd3
  } state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; unknown
// patterns give nibble 0 with invalid set.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_readback.sv
// Samples a multiplexed seven-segment display bus, decodes each digit once
// its select has settled, and presents complete frames on a valid/ready port.
//
//   state    | meaning
//   WAIT_SEL | waiting for exactly one digit select low
//   SETTLE   | select stable, counting settle cycles
//   LATCH    | write decoded digit into frame buffer and capture mask
//   HOLD     | digit captured, waiting for select to move
module seg_readback
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [6:0]              Seg_In,
  input  logic [NUM_DIGITS-1:0]   Dig_Sel,
  output logic [4*NUM_DIGITS-1:0] Word,
  output logic [NUM_DIGITS-1:0]   Word_Err,
  output logic                    Word_Valid,
  input  logic                    Word_Ready,
  output logic                    Overrun
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e                  state;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic [IW-1:0]           idx_q;
  logic [3:0]              cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] fbuf_word;
  logic [NUM_DIGITS-1:0]   fbuf_err;

  logic [NUM_DIGITS-1:0]   sel_n;
  logic                    onehot;
  logic [IW-1:0]           sel_idx;
  logic [3:0]              dec_nib;
  logic                    dec_err;
  logic                    frame_done;

  assign sel_n      = ~Dig_Sel;
  assign onehot     = (sel_n != '0) && ((sel_n & (sel_n - NUM_DIGITS'(1))) == '0);
  assign frame_done = &mask;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_n[i]) sel_idx = IW'(i);
    end
  end

  seg_decode u_dec (
    .seg     (Seg_In),
    .nibble  (dec_nib),
    .invalid (dec_err)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= WAIT_SEL;
      sel_q      <= '1;
      idx_q      <= '0;
      cnt        <= '0;
      mask       <= '0;
      fbuf_word  <= '0;
      fbuf_err   <= '0;
      Word       <= '0;
      Word_Err   <= '0;
      Word_Valid <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      case (state)
        WAIT_SEL: begin
          if (onehot) begin
            sel_q <= Dig_Sel;
            idx_q <= sel_idx;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (Dig_Sel == sel_q) begin
            if (cnt == CNT_LAST) state <= LATCH;
            else                 cnt   <= cnt + 4'd1;
          end else if (onehot) begin
            sel_q <= Dig_Sel;
            idx_q <= sel_idx;
            cnt   <= '0;
          end else begin
            state <= WAIT_SEL;
          end
        end
        LATCH: begin
          fbuf_word[{idx_q, 2'b00} +: 4] <= dec_nib;
          fbuf_err[idx_q]                <= dec_err;
          mask[idx_q]                    <= 1'b1;
          state                          <= HOLD;
        end
        HOLD: begin
          if (Dig_Sel != sel_q) begin
            if (onehot) begin
              sel_q <= Dig_Sel;
              idx_q <= sel_idx;
              cnt   <= '0;
              state <= SETTLE;
            end else begin
              state <= WAIT_SEL;
            end
          end
        end
        default: state <= WAIT_SEL;
      endcase

      // LATCH is never active in the completion cycle (FSM is in HOLD then)
      if (frame_done) begin
        mask <= '0;
        if (!Word_Valid || Word_Ready) begin
          Word       <= fbuf_word;
          Word_Err   <= fbuf_err;
          Word_Valid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Word_Valid && Word_Ready) begin
        Word_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback: stimulus pushes expected frames into a
// queue, a monitor pops and compares on every accepted word.
module tb_seg_readback;
  import seg_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [6:0]  Seg_In;
  logic [7:0]  Dig_Sel;
  logic [31:0] Word;
  logic [7:0]  Word_Err;
  logic        Word_Valid;
  logic        Word_Ready;
  logic        Overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  err;
  } exp_t;

  exp_t q[$];

  always #5 Clk = ~Clk;

  seg_readback #(.NUM_DIGITS(8), .SETTLE_CYCLES(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Seg_In     (Seg_In),
    .Dig_Sel    (Dig_Sel),
    .Word       (Word),
    .Word_Err   (Word_Err),
    .Word_Valid (Word_Valid),
    .Word_Ready (Word_Ready),
    .Overrun    (Overrun)
  );

  logic [6:0] p_count [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  logic [6:0] p_blank [8] = '{7'h00, 7'h00, 7'h00, 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [6:0] p_four  [8] = '{7'h19, 7'h19, 7'h19, 7'h19, 7'h19, 7'h19, 7'h19, 7'h19};
  logic [6:0] p_f     [8] = '{7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
  logic [6:0] p_hi    [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         order   [8] = '{5, 6, 7, 0, 1, 2, 3, 4};

  // Monitor: a word is consumed when Valid and Ready are both high at the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && Word_Valid && Word_Ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got word=%h err=%h, no frame expected", Word, Word_Err);
        end else begin
          e = q.pop_front();
          if (Word !== e.word || Word_Err !== e.err) begin
            errors++;
            $display("FAIL frame: got word=%h err=%h, expected word=%h err=%h",
                     Word, Word_Err, e.word, e.err);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic show_digit(input int idx, input logic [6:0] seg, input int hold);
    cyc();
    Dig_Sel = ~(8'(1) << idx);
    Seg_In  = seg;
    repeat (hold - 1) cyc();
  endtask

  task automatic scan(input logic [6:0] s [8]);
    for (int i = 0; i < 8; i++) show_digit(i, s[i], 6);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc();
      Dig_Sel = '1;
      Seg_In  = '1;
    end
  endtask

  task automatic reset_checks(input string tag);
    @(negedge Clk);
    chk({tag, "_word"},    Word,              32'h0);
    chk({tag, "_err"},     {24'h0, Word_Err}, 32'h0);
    chk({tag, "_valid"},   {31'h0, Word_Valid}, 32'h0);
    chk({tag, "_overrun"}, {31'h0, Overrun},  32'h0);
  endtask

  initial begin
    int vcnt;
    Reset      = 1'b1;
    Word_Ready = 1'b1;
    Dig_Sel    = '1;
    Seg_In     = '1;
    repeat (3) cyc();
    Reset = 1'b0;
    reset_checks("reset");

    // Counting scan, consumer always ready: one-cycle Valid pulse
    q.push_back('{32'h76543210, 8'h00});
    scan(p_count);
    vcnt = 0;
    repeat (8) begin
      idle(1);
      @(negedge Clk);
      if (Word_Valid) vcnt++;
    end
    chk("valid_pulse_cycles", vcnt, 1);

    // Blank digit 3 decodes to 0 with its error bit
    q.push_back('{32'h88880888, 8'h08});
    scan(p_blank);
    idle(6);

    // Digit 0 held only 3 cycles: must not latch, so no frame after digits 1..7
    show_digit(0, 7'h79, 3);
    for (int i = 1; i < 8; i++) show_digit(i, 7'h30, 6);
    vcnt = 0;
    repeat (6) begin
      idle(1);
      @(negedge Clk);
      if (Word_Valid) vcnt++;
    end
    chk("short_hold_no_frame", vcnt, 0);
    q.push_back('{32'h33333332, 8'h00});
    show_digit(0, 7'h24, 6);
    idle(6);

    // Consumer stalled across two frames: first held, second dropped
    Word_Ready = 1'b0;
    q.push_back('{32'h76543210, 8'h00});
    scan(p_count);
    scan(p_four);
    idle(4);
    @(negedge Clk);
    chk("stall_word_held", Word, 32'h76543210);
    chk("stall_err_held",  {24'h0, Word_Err}, 32'h0);
    chk("stall_valid",     {31'h0, Word_Valid}, 32'h1);
    chk("stall_overrun",   {31'h0, Overrun}, 32'h1);
    cyc();
    Word_Ready = 1'b1;
    cyc();
    @(negedge Clk);
    chk("valid_falls_after_ready", {31'h0, Word_Valid}, 32'h0);
    chk("overrun_sticky",          {31'h0, Overrun}, 32'h1);

    // Frame completes in the same cycle the held word is accepted
    cyc();
    Reset = 1'b1;
    cyc();
    cyc();
    Reset      = 1'b0;
    Word_Ready = 1'b0;
    q.push_back('{32'h76543210, 8'h00});
    q.push_back('{32'hFFFFFFFF, 8'h00});
    scan(p_count);
    idle(4);
    scan(p_f);
    cyc();
    Word_Ready = 1'b1;
    cyc();
    Word_Ready = 1'b0;
    @(negedge Clk);
    chk("reload_valid_stays", {31'h0, Word_Valid}, 32'h1);
    chk("reload_word",        Word, 32'hFFFFFFFF);
    chk("reload_no_overrun",  {31'h0, Overrun}, 32'h0);
    cyc();
    Word_Ready = 1'b1;
    idle(4);

    // Reset after five digits: partial captures discarded
    for (int i = 0; i < 5; i++) show_digit(i, 7'h40, 6);
    cyc();
    Reset   = 1'b1;
    Dig_Sel = '1;
    cyc();
    cyc();
    Reset = 1'b0;
    reset_checks("midframe_reset");
    q.push_back('{32'hFEDCBA98, 8'h00});
    for (int k = 0; k < 8; k++) show_digit(order[k], p_hi[order[k]], 6);
    idle(6);

    // Two selects low is not a valid digit select
    cyc();
    Dig_Sel = 8'hFC;
    Seg_In  = 7'h40;
    repeat (10) cyc();
    @(negedge Clk);
    chk("two_low_wait_sel", 32'(dut.state), 32'(WAIT_SEL));
    chk("two_low_no_valid", {31'h0, Word_Valid}, 32'h0);
    idle(3);

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
